sram_sqi_arbiter: RTL and testbench
===================================

SRAM_SQI_ARBITER -- requirements
Module: sram_sqi_arbiter

Interface
REQ-001 The block SHALL have parameter CMD_WRITE, default 8'h02, SQI write opcode.
REQ-002 The block SHALL have parameter CMD_READ, default 8'h03, SQI read opcode.
REQ-003 The block SHALL have parameter DUMMY_NIBBLES, default 2, read turnaround nibbles; legal range 1..4.
REQ-004 The block SHALL have these ports:
- clock  in  1  system clock; one clock domain, all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_valid, a_write  in  1 each  port A request valid, 1=write / 0=read.
- a_addr  in  24  port A byte address.
- a_wdata  in  8  port A write data.
- a_ready  out  1  port A request accepted this cycle.
- b_valid, b_write, b_addr, b_wdata, b_ready  same as port A, for port B.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  1  completed port, 0=A / 1=B.
- rsp_rdata  out  8  read data; holds last value after writes.
- busy  out  1  high in every state except IDLE.
- sram_clock  out  1  SRAM serial clock.
- sram_cs  out  1  SRAM chip select, active low.
- sram_sio_oe  out  1  drive enable for all four sio pins.
- sram_sio_dout  out  4  nibble to drive.
- sram_sio_din  in  4  nibble sampled from the pins.

Function
REQ-005 The block SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA and DONE; DUMMY SHALL be entered only for reads.
REQ-006 In IDLE with exactly one valid port, the block SHALL grant that port; with both valid, it SHALL grant the port not granted last.
REQ-007 The block SHALL initialise the last-grant record to B, so that A wins the first contention.
REQ-008 ready SHALL be combinational: high only in IDLE, only for the granted port, and only while that port's valid is high; at most one ready SHALL be high per cycle.
REQ-009 At grant cycle T, the block SHALL register write, addr, wdata and id, and SHALL leave IDLE at T+1.
REQ-010 Each nibble k (k=0..) SHALL occupy two cycles:
- sram_clock=0 at T+1+2k and sram_clock=1 at T+2+2k.
- sram_sio_dout SHALL be stable across both cycles.
REQ-011 Nibble order SHALL be MSB first:
- opcode[7:4], opcode[3:0] (CMD).
- addr[23:20] .. addr[3:0] (ADDR, 6 nibbles).
- write: wdata[7:4], wdata[3:0] (DATA).
- read: DUMMY_NIBBLES dummy nibbles of 4'h0, then 2 data nibbles.
REQ-012 sram_sio_oe SHALL be 1 for every CMD, ADDR and write-DATA nibble, and 0 from the first DUMMY cycle until the end of DONE.
REQ-013 For read data nibbles, the block SHALL capture sram_sio_din on the clock edge that ends the sram_clock=1 cycle; the first data nibble SHALL fill rdata[7:4] and the second rdata[3:0].
REQ-014 sram_cs SHALL be 0 from T+1 through the last high phase, i.e. 20 cycles for a write and 2*(10+DUMMY_NIBBLES) cycles for a read.
REQ-015 DONE SHALL last exactly one cycle, with sram_cs=1, sram_clock=0 and sram_sio_oe=0.
REQ-016 In DONE, the block SHALL pulse rsp_valid with rsp_id, and SHALL update rsp_rdata only when the operation is a read.
REQ-017 The block SHALL return to IDLE after DONE; the earliest next grant is T+22 for a write and T+26 for a read (DUMMY_NIBBLES=2).
REQ-018 The block SHALL ignore request inputs while busy; requesters SHALL hold valid until they see ready.
REQ-019 The block SHALL NOT check for addr wrap-around; addr SHALL be passed through unchanged, and 24'hFFFFFF SHALL be legal.

Reset
REQ-020 While reset=1, the block SHALL asynchronously force:
- state=IDLE; last-grant=B.
- sram_cs=1, sram_clock=0, sram_sio_oe=0, sram_sio_dout=0.
- rsp_valid=0, rsp_rdata=0, busy=0, a_ready=0, b_ready=0.
REQ-021 Reset mid-transaction SHALL abort the transaction with no rsp_valid; after release, the first grant SHALL be possible on the first clock edge.

Verification
REQ-022 Bench SHALL cover: A write, addr 24'h012345, wdata 8'hA5 -> dout nibbles 0,2,0,1,2,3,4,5,A,5; oe=1 and cs=0 for 20 cycles; rsp_valid at T+21 with rsp_id=0.
REQ-023 Bench SHALL cover: B read, addr 24'h00FF00, SRAM model returns 8'h3C -> nibbles 0,3,0,0,F,F,0,0; oe=0 from T+17; rsp_rdata=8'h3C and rsp_id=1 at T+25.
REQ-024 Bench SHALL cover: A and B valid every cycle from reset -> grants alternate A,B,A,B; rsp_id sequence 0,1,0,1.
REQ-025 Bench SHALL cover: only A valid, held continuously with writes -> grants at T, T+22, T+44; B never readied.
REQ-026 Bench SHALL cover: reset asserted during an ADDR nibble -> cs=1, oe=0 and clock=0 immediately, no rsp_valid; a fresh read after release returns the correct data.
REQ-027 Bench SHALL cover: read at addr 24'hFFFFFF -> address nibbles F,F,F,F,F,F, completes normally.

Source files
------------

// File: rtl/sram_sqi_arbiter.sv
// Two-port round-robin arbiter driving a single quad-SPI (SQI) SRAM, one byte per transaction.
// Each nibble spends one cycle with sram_clock low and one high; read data is sampled at the end of the high cycle.
module sram_sqi_arbiter #(
  parameter logic [7:0] CMD_WRITE     = 8'h02,
  parameter logic [7:0] CMD_READ      = 8'h03,
  parameter int         DUMMY_NIBBLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  input  logic        a_write,
  input  logic [23:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic        b_write,
  input  logic [23:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        sram_clock,
  output logic        sram_cs,
  output logic        sram_sio_oe,
  output logic [3:0]  sram_sio_dout,
  input  logic [3:0]  sram_sio_din
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_t;

  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_NIBBLES - 1);

  state_t      state_q, state_d;
  logic        last_b_q, last_b_d;
  logic        wr_q, wr_d;
  logic        id_q, id_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        phase_q, phase_d;
  logic [2:0]  nib_q, nib_d;
  logic [3:0]  rd_hi_q, rd_hi_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        gnt_a, gnt_b, active;
  logic [7:0]  opcode;
  logic [23:0] addr_sh;

  // On contention the port that did not win last time takes the grant.
  assign gnt_b   = b_valid && (!a_valid || !last_b_q);
  assign gnt_a   = a_valid && !gnt_b;
  assign a_ready = !reset && (state_q == S_IDLE) && gnt_a;
  assign b_ready = !reset && (state_q == S_IDLE) && gnt_b;

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    wr_d     = wr_q;
    id_d     = id_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    phase_d  = phase_q;
    nib_d    = nib_q;
    rd_hi_d  = rd_hi_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_a || gnt_b) begin
          state_d  = S_CMD;
          wr_d     = gnt_b ? b_write : a_write;
          addr_d   = gnt_b ? b_addr : a_addr;
          wdata_d  = gnt_b ? b_wdata : a_wdata;
          id_d     = gnt_b;
          last_b_d = gnt_b;
          phase_d  = 1'b0;
          nib_d    = 3'd0;
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        phase_d = !phase_q;
        if (phase_q) begin
          nib_d = nib_q + 3'd1;
          case (state_q)
            S_CMD: if (nib_q == 3'd1) begin state_d = S_ADDR; nib_d = 3'd0; end
            S_ADDR: if (nib_q == 3'd5) begin
              state_d = wr_q ? S_DATA : S_DUMMY;
              nib_d   = 3'd0;
            end
            S_DUMMY: if (nib_q == DUMMY_LAST) begin state_d = S_DATA; nib_d = 3'd0; end
            default: begin
              if (nib_q == 3'd0) begin
                rd_hi_d = sram_sio_din;
              end else begin
                state_d = S_DONE;
                nib_d   = 3'd0;
                if (!wr_q) rdata_d = {rd_hi_q, sram_sio_din};
              end
            end
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_b_q <= 1'b1;
      wr_q     <= 1'b0;
      id_q     <= 1'b0;
      addr_q   <= 24'h0;
      wdata_q  <= 8'h0;
      phase_q  <= 1'b0;
      nib_q    <= 3'd0;
      rd_hi_q  <= 4'h0;
      rdata_q  <= 8'h0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      wr_q     <= wr_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      phase_q  <= phase_d;
      nib_q    <= nib_d;
      rd_hi_q  <= rd_hi_d;
      rdata_q  <= rdata_d;
    end
  end

  // Pin outputs decode straight from state so reset forces them idle at once.
  assign active      = (state_q == S_CMD) || (state_q == S_ADDR) ||
                       (state_q == S_DUMMY) || (state_q == S_DATA);
  assign sram_cs     = !active;
  assign sram_clock  = active && phase_q;
  assign sram_sio_oe = (state_q == S_CMD) || (state_q == S_ADDR) ||
                       ((state_q == S_DATA) && wr_q);
  assign busy        = (state_q != S_IDLE);
  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_id      = id_q;
  assign rsp_rdata   = rdata_q;
  assign opcode      = wr_q ? CMD_WRITE : CMD_READ;
  assign addr_sh     = addr_q << {nib_q, 2'b00};

  always_comb begin
    sram_sio_dout = 4'h0;
    case (state_q)
      S_CMD:   sram_sio_dout = nib_q[0] ? opcode[3:0] : opcode[7:4];
      S_ADDR:  sram_sio_dout = addr_sh[23:20];
      S_DATA:  if (wr_q) sram_sio_dout = nib_q[0] ? wdata_q[3:0] : wdata_q[7:4];
      default: sram_sio_dout = 4'h0;
    endcase
  end

endmodule

// File: tb/tb_sram_sqi_arbiter.sv
// Bench for sram_sqi_arbiter: behavioural SQI SRAM, response scoreboard, vector table plus
// hand-written contention and reset sequences.
module tb_sram_sqi_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, a_write = 1'b0, b_valid = 1'b0, b_write = 1'b0;
  logic [23:0] a_addr = 24'h0, b_addr = 24'h0;
  logic [7:0]  a_wdata = 8'h0, b_wdata = 8'h0;
  logic        a_ready, b_ready, rsp_valid, rsp_id, busy;
  logic [7:0]  rsp_rdata;
  logic        sram_clock, sram_cs, sram_sio_oe;
  logic [3:0]  sram_sio_dout;
  logic [3:0]  sram_sio_din = 4'h0;

  sram_sqi_arbiter dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata), .a_ready(a_ready),
    .b_valid(b_valid), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata), .b_ready(b_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .busy(busy),
    .sram_clock(sram_clock), .sram_cs(sram_cs), .sram_sio_oe(sram_sio_oe),
    .sram_sio_dout(sram_sio_dout), .sram_sio_din(sram_sio_din)
  );

  always #5 clock = !clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model and monitor state
  logic [7:0]  sram_byte = 8'h00;
  logic [7:0]  exp_last = 8'h00;
  logic [7:0]  last_rsp_rdata = 8'h00;
  bit          sb_id[$];
  logic [7:0]  sb_rd[$];
  logic [3:0]  nib_log[$];
  bit          oe_log[$];
  bit          stab_log[$];
  bit          gnt_log[$];
  bit          rsp_log[$];
  int          gnt_cyc_log[$];
  int          idx = 0, cs_cnt = 0, cs_start = -1, rsp_cyc = -1, rsp_cnt = 0, b_ready_cnt = 0;
  bit          cs_prev = 1'b1, cs_start_clk = 1'b0, mon_wr;
  logic [3:0]  low_dout = 4'h0;
  bit          low_oe = 1'b0;

  function automatic logic [3:0] din_for(input int i);
    logic [7:0] b;
    b = sram_byte;
    if (i == 10) return b[7:4];
    if (i == 11) return b[3:0];
    return 4'hE;
  endfunction

  function automatic logic [3:0] exp_nib(input bit wr, input logic [23:0] addr,
                                         input logic [7:0] wd, input int k);
    logic [7:0]  op;
    logic [23:0] a;
    op = wr ? 8'h02 : 8'h03;
    if (k == 0) return op[7:4];
    if (k == 1) return op[3:0];
    if (k < 8) begin
      a = addr >> (4 * (7 - k));
      return a[3:0];
    end
    if (wr) return (k == 8) ? wd[7:4] : wd[3:0];
    return 4'h0;
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      idx = 0;
      sb_id.delete();
      sb_rd.delete();
      exp_last = 8'h00;
      cs_prev = 1'b1;
      sram_sio_din = 4'h0;
    end else begin
      if (sram_cs) idx = 0;
      sram_sio_din = din_for(idx);
      if (!sram_cs) begin
        cs_cnt++;
        if (cs_prev) begin cs_start = cyc; cs_start_clk = sram_clock; end
        if (!sram_clock) begin
          low_dout = sram_sio_dout;
          low_oe = sram_sio_oe;
        end else begin
          nib_log.push_back(sram_sio_dout);
          oe_log.push_back(sram_sio_oe);
          stab_log.push_back((low_dout == sram_sio_dout) && (low_oe == sram_sio_oe));
          idx++;
        end
      end
      cs_prev = sram_cs;
      if (a_ready || b_ready) begin
        chk("one_ready", a_ready && b_ready, 0);
        chk("ready_needs_valid", (a_ready && !a_valid) || (b_ready && !b_valid), 0);
        gnt_log.push_back(b_ready);
        gnt_cyc_log.push_back(cyc);
        if (b_ready) b_ready_cnt++;
        mon_wr = b_ready ? b_write : a_write;
        sb_id.push_back(b_ready);
        sb_rd.push_back(mon_wr ? exp_last : sram_byte);
        if (!mon_wr) exp_last = sram_byte;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        rsp_log.push_back(rsp_id);
        last_rsp_rdata = rsp_rdata;
        chk("done_cs", sram_cs, 1);
        chk("done_clk", sram_clock, 0);
        chk("done_oe", sram_sio_oe, 0);
        chk("rsp_expected", sb_id.size() > 0, 1);
        if (sb_id.size() > 0) begin
          chk("rsp_id", rsp_id, sb_id.pop_front());
          chk("rsp_rdata", rsp_rdata, sb_rd.pop_front());
        end
      end
    end
  end

  task automatic clear_logs();
    nib_log.delete(); oe_log.delete(); stab_log.delete();
    gnt_log.delete(); rsp_log.delete(); gnt_cyc_log.delete();
    cs_cnt = 0; cs_start = -1; rsp_cyc = -1; b_ready_cnt = 0;
  endtask

  // Must be called just after a rising edge.
  task automatic run_req(input bit port, input bit wr, input logic [23:0] addr,
                         input logic [7:0] wd, output int gnt);
    bit got;
    #1;
    if (port) begin b_valid = 1; b_write = wr; b_addr = addr; b_wdata = wd; end
    else begin a_valid = 1; a_write = wr; a_addr = addr; a_wdata = wd; end
    got = 0;
    gnt = -1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clock);
      if (port ? b_ready : a_ready) begin got = 1; gnt = cyc; end
    end
    @(posedge clock);
    #1;
    a_valid = 0;
    b_valid = 0;
    chk("grant_seen", got, 1);
  endtask

  task automatic wait_rsp(input int target, input string name);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 200) begin @(posedge clock); n++; end
    chk(name, rsp_cnt >= target, 1);
  endtask

  task automatic do_reset();
    #1;
    reset = 1; a_valid = 0; b_valid = 0;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    bit          port;
    bit          wr;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  sram;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int gnt, n0, nn, rel, n;
    vecs[0] = '{1'b0, 1'b1, 24'h012345, 8'hA5, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 24'h00FF00, 8'h00, 8'h3C, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 24'hFFFFFF, 8'h00, 8'h96, 8'h96};
    vecs[3] = '{1'b1, 1'b1, 24'h800001, 8'h5A, 8'h11, 8'h96};
    vecs[4] = '{1'b0, 1'b0, 24'h000000, 8'h00, 8'hC3, 8'hC3};

    // Reset state with both requesters asserting valid
    a_valid = 1; b_valid = 1;
    repeat (3) @(posedge clock);
    #2;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_cs", sram_cs, 1);
    chk("rst_clk", sram_clock, 0);
    chk("rst_oe", sram_sio_oe, 0);
    chk("rst_dout", sram_sio_dout, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    a_valid = 0; b_valid = 0;
    #1 reset = 0;
    @(posedge clock);

    for (int v = 0; v < 5; v++) begin
      sram_byte = vecs[v].sram;
      clear_logs();
      n0 = rsp_cnt;
      run_req(vecs[v].port, vecs[v].wr, vecs[v].addr, vecs[v].wdata, gnt);
      wait_rsp(n0 + 1, "vec_rsp_timeout");
      nn = vecs[v].wr ? 10 : 12;
      chk("vec_cs_start", cs_start, gnt + 1);
      chk("vec_cs_start_clk", cs_start_clk, 0);
      chk("vec_cs_len", cs_cnt, vecs[v].wr ? 20 : 24);
      chk("vec_rsp_cycle", rsp_cyc, gnt + (vecs[v].wr ? 21 : 25));
      chk("vec_rdata", last_rsp_rdata, vecs[v].exp_rdata);
      chk("vec_nibble_count", nib_log.size(), nn);
      for (int k = 0; k < nn && k < nib_log.size(); k++) begin
        chk("vec_oe", oe_log[k], (vecs[v].wr || k < 8) ? 1 : 0);
        chk("vec_nibble_stable", stab_log[k], 1);
        if (vecs[v].wr || k < 10)
          chk("vec_nibble", nib_log[k], exp_nib(vecs[v].wr, vecs[v].addr, vecs[v].wdata, k));
      end
    end

    // Both ports valid every cycle from reset: A first, then alternating
    do_reset();
    clear_logs();
    a_write = 1; b_write = 1; a_addr = 24'h000100; b_addr = 24'h000200;
    a_wdata = 8'h11; b_wdata = 8'h22;
    a_valid = 1; b_valid = 1;
    n0 = rsp_cnt;
    wait_rsp(n0 + 4, "alt_rsp_timeout");
    #1 a_valid = 0; b_valid = 0;
    chk("alt_grant_count", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_log.size()) chk("alt_grant_port", gnt_log[i], i & 1);
      if (i < rsp_log.size()) chk("alt_rsp_id", rsp_log[i], i & 1);
    end

    // Only A valid, held continuously with writes
    do_reset();
    clear_logs();
    a_write = 1; a_addr = 24'h000300; a_wdata = 8'h33;
    a_valid = 1;
    n0 = rsp_cnt;
    wait_rsp(n0 + 3, "aonly_rsp_timeout");
    #1 a_valid = 0;
    chk("aonly_grant_count", gnt_cyc_log.size(), 3);
    if (gnt_cyc_log.size() >= 3) begin
      chk("aonly_gap1", gnt_cyc_log[1] - gnt_cyc_log[0], 22);
      chk("aonly_gap2", gnt_cyc_log[2] - gnt_cyc_log[1], 22);
    end
    chk("aonly_b_ready", b_ready_cnt, 0);

    // Reset during an ADDR nibble, then a fresh read
    do_reset();
    sram_byte = 8'h5C;
    clear_logs();
    n0 = rsp_cnt;
    run_req(0, 0, 24'h000010, 8'h00, gnt);
    n = 0;
    while (nib_log.size() < 4 && n < 50) begin @(posedge clock); n++; end
    chk("mid_reached_addr", nib_log.size() >= 4, 1);
    #2 reset = 1;
    #1;
    chk("mid_cs", sram_cs, 1);
    chk("mid_oe", sram_sio_oe, 0);
    chk("mid_clk", sram_clock, 0);
    chk("mid_dout", sram_sio_dout, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    a_valid = 1; a_write = 0; a_addr = 24'h00ABCD; sram_byte = 8'h71;
    #1 chk("mid_a_ready", a_ready, 0);
    repeat (2) @(posedge clock);
    chk("mid_no_rsp", rsp_cnt, n0);
    #2 reset = 0;
    rel = cyc;
    clear_logs();
    #1 chk("release_ready", a_ready, 1);
    run_req(0, 0, 24'h00ABCD, 8'h00, gnt);
    chk("release_first_grant", gnt, rel);
    wait_rsp(n0 + 1, "release_rsp_timeout");
    chk("release_rsp_cycle", rsp_cyc, gnt + 25);
    chk("release_rdata", last_rsp_rdata, 8'h71);
    chk("release_nibbles", nib_log.size(), 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

endmodule
